// File: rtl/lsu_align_if.sv
// Bundle between the execute-side issuer, the lsu_align stage and the data bus.
// The lsu_align stage itself uses the slave view.
interface lsu_align_if;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  logic        op_valid;
  logic        op_ready;
  logic        op_load;
  logic        op_store;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic [63:0] op_addr;
  logic [63:0] op_wdata;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;
  logic        done;
  logic [63:0] rdata;
  logic        misalign;

  modport master (
    output op_valid, op_load, op_store, op_size,
    output op_unsigned, op_addr, op_wdata, dresp,
    input  op_ready, dreq, done, rdata, misalign
  );

  modport slave (
    input  op_valid, op_load, op_store, op_size,
    input  op_unsigned, op_addr, op_wdata, dresp,
    output op_ready, dreq, done, rdata, misalign
  );
endinterface

// File: rtl/lsu_align.sv
// Load/store alignment stage: checks natural alignment, builds a lane-correct
// data bus request, and extends returned load data.
module lsu_align #(
  parameter int XLEN      = 64,
  parameter int BUS_BYTES = 8
) (
  input  logic       clk,
  input  logic       rst,
  lsu_align_if.slave bus
);
  localparam int OFF_W = $clog2(BUS_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0]  addr_q;
  logic [XLEN-1:0]  data_q;
  logic [XLEN-1:0]  rdata_q;
  logic [2:0]       size_q;
  logic [7:0]       strb_q;
  logic             load_q;
  logic             uns_q;
  logic             mis_q;

  logic             accept;
  logic             mis;
  logic [7:0]       strb_base;
  logic [OFF_W-1:0] off;
  logic [OFF_W-1:0] off_q;
  logic [XLEN-1:0]  sh;
  logic [XLEN-1:0]  ext;
  logic             unused_addr_ok;

  assign unused_addr_ok = bus.dresp.addr_ok;

  assign off    = bus.op_addr[OFF_W-1:0];
  assign off_q  = addr_q[OFF_W-1:0];
  assign accept = (state_q == IDLE) && bus.op_valid
                  && (bus.op_load || bus.op_store);

  always_comb begin
    mis       = 1'b0;
    strb_base = 8'h01;
    unique case (bus.op_size)
      2'd0: begin
        mis       = 1'b0;
        strb_base = 8'h01;
      end
      2'd1: begin
        mis       = off[0];
        strb_base = 8'h03;
      end
      2'd2: begin
        mis       = |off[1:0];
        strb_base = 8'h0f;
      end
      default: begin
        mis       = |off[2:0];
        strb_base = 8'hff;
      end
    endcase
  end

  // Returned word is lane-shifted down before width selection.
  assign sh = bus.dresp.data >> {off_q, 3'b000};

  always_comb begin
    ext = sh;
    unique case (size_q[1:0])
      2'd0: ext = {{56{sh[7] & ~uns_q}}, sh[7:0]};
      2'd1: ext = {{48{sh[15] & ~uns_q}}, sh[15:0]};
      2'd2: ext = {{32{sh[31] & ~uns_q}}, sh[31:0]};
      default: ext = sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = mis ? RESP : WAIT;
      WAIT: if (bus.dresp.data_ok) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.op_ready = (state_q == IDLE);
    bus.done     = (state_q == RESP);
    bus.misalign = mis_q;
    bus.rdata    = rdata_q;
    bus.dreq     = {state_q == WAIT, addr_q, size_q, strb_q, data_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      strb_q  <= '0;
      load_q  <= 1'b0;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept && !mis) begin
        addr_q <= bus.op_addr;
        size_q <= {1'b0, bus.op_size};
        load_q <= bus.op_load;
        uns_q  <= bus.op_unsigned;
        strb_q <= bus.op_load ? 8'h00 : strb_base << off;
        data_q <= bus.op_load ? '0
                              : bus.op_wdata << {off, 3'b000};
      end
      if (accept && mis) begin
        mis_q   <= 1'b1;
        rdata_q <= '0;
      end
      if (state_q == WAIT && bus.dresp.data_ok) begin
        mis_q   <= 1'b0;
        rdata_q <= load_q ? ext : '0;
      end
    end
  end
endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: directed scenarios plus randomized ops checked
// against an arithmetic model of the alignment rules.
module tb_lsu_align;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  lsu_align_if bus ();

  lsu_align dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          waited, lat;
  logic        saw_v, held, rdy_low, pulse1, m;
  logic [63:0] q_addr, q_data, r;
  logic [2:0]  q_size;
  logic [7:0]  q_strb;

  function automatic logic [63:0] m_rdata(logic [63:0] d, logic [2:0] off,
                                          logic [1:0] sz, logic uns);
    int nb;
    logic [63:0] s, mask, v;
    nb   = 1 << sz;
    s    = d >> (int'(off) * 8);
    mask = (nb == 8) ? 64'hffff_ffff_ffff_ffff : (64'd1 << (nb * 8)) - 64'd1;
    v    = s & mask;
    if (!uns && nb < 8 && s[nb*8-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [7:0] m_strb(logic [2:0] off, logic [1:0] sz);
    int s;
    s = ((1 << (1 << sz)) - 1) << int'(off);
    return s[7:0];
  endfunction

  function automatic logic m_mis(logic [63:0] a, logic [1:0] sz);
    return (a % (64'd1 << sz)) != 64'd0;
  endfunction

  task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                       input logic uns, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [63:0] rd,
                       input int k);
    waited = 0;
    while (!bus.op_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    bus.op_valid    = 1'b1;
    bus.op_load     = ld;
    bus.op_store    = st;
    bus.op_size     = sz;
    bus.op_unsigned = uns;
    bus.op_addr     = addr;
    bus.op_wdata    = wd;
    @(posedge clk); #1;
    bus.op_valid    = 1'b0;
    bus.op_load     = 1'($urandom);
    bus.op_store    = 1'($urandom);
    bus.op_size     = 2'($urandom);
    bus.op_unsigned = 1'($urandom);
    bus.op_addr     = {$urandom, $urandom};
    bus.op_wdata    = {$urandom, $urandom};
    lat = 0; saw_v = 0; held = 1; rdy_low = 1;
    q_addr = '0; q_size = '0; q_strb = '0; q_data = '0;
    for (int c = 1; c <= 50; c++) begin
      if (bus.op_ready) rdy_low = 0;
      if (bus.dreq.valid) begin
        if (!saw_v) begin
          saw_v  = 1;
          q_addr = bus.dreq.addr;
          q_size = bus.dreq.size;
          q_strb = bus.dreq.strobe;
          q_data = bus.dreq.data;
        end else if (bus.dreq.addr !== q_addr || bus.dreq.size !== q_size ||
                     bus.dreq.strobe !== q_strb || bus.dreq.data !== q_data)
          held = 0;
      end
      if (bus.done) begin
        lat = c;
        break;
      end
      bus.dresp.data_ok = (c == k);
      bus.dresp.data    = (c == k) ? rd : {$urandom, $urandom};
      @(posedge clk); #1;
    end
    r = bus.rdata;
    m = bus.misalign;
    bus.dresp.data_ok = 1'b0;
    @(posedge clk); #1;
    pulse1 = !bus.done;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.op_valid = 0; bus.op_load = 0; bus.op_store = 0; bus.op_size = 0;
    bus.op_unsigned = 0; bus.op_addr = '0; bus.op_wdata = '0;
    bus.dresp = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.dreq !== '0) begin
      errors++; $display("FAIL reset_dreq got %h exp 0", bus.dreq);
    end
    checks++;
    if ({bus.done, bus.misalign} !== 2'b00) begin
      errors++; $display("FAIL reset_done_mis got %b exp 00", {bus.done, bus.misalign});
    end
    checks++;
    if (bus.rdata !== 64'd0) begin
      errors++; $display("FAIL reset_rdata got %h exp 0", bus.rdata);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.op_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b exp 1", bus.op_ready);
    end
  endtask

  task automatic test_byte_load;
    issue(1, 0, 2'd0, 0, 64'h8000_0002, 64'd0, 64'h0123_4567_89ab_cdef, 1);
    checks++;
    if ({lat, q_size, q_strb} !== {32'd2, 3'd0, 8'h00}) begin
      errors++; $display("FAIL lb_req got lat=%0d size=%0d strb=%h exp 2 0 00", lat, q_size, q_strb);
    end
    checks++;
    if (r !== 64'hffff_ffff_ffff_ffab) begin
      errors++; $display("FAIL lb_rdata got %h exp ffffffffffffffab", r);
    end
    issue(1, 0, 2'd0, 1, 64'h8000_0002, 64'd0, 64'h0123_4567_89ab_cdef, 1);
    checks++;
    if (r !== 64'h0000_0000_0000_00ab || lat != 2) begin
      errors++; $display("FAIL lbu_rdata got %h lat=%0d exp ab lat=2", r, lat);
    end
  endtask

  task automatic test_half_store;
    issue(0, 1, 2'd1, 0, 64'h8000_0006, 64'h1234, 64'hdead, 1);
    checks++;
    if ({q_addr, q_size, q_strb} !== {64'h8000_0006, 3'd1, 8'hc0}) begin
      errors++; $display("FAIL sh_req got addr=%h size=%0d strb=%h exp 80000006 1 c0", q_addr, q_size, q_strb);
    end
    checks++;
    if (q_data !== 64'h1234_0000_0000_0000) begin
      errors++; $display("FAIL sh_data got %h exp 1234000000000000", q_data);
    end
    checks++;
    if ({lat, r, m, pulse1} !== {32'd2, 64'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL sh_done got lat=%0d r=%h m=%b p=%b exp 2 0 0 1", lat, r, m, pulse1);
    end
  endtask

  task automatic test_misalign;
    issue(1, 0, 2'd2, 0, 64'h8000_0002, 64'd0, 64'hffff_ffff_ffff_ffff, 1);
    checks++;
    if ({saw_v, lat, m, r, pulse1} !== {1'b0, 32'd1, 1'b1, 64'd0, 1'b1}) begin
      errors++; $display("FAIL lw_mis got v=%b lat=%0d m=%b r=%h p=%b exp 0 1 1 0 1", saw_v, lat, m, r, pulse1);
    end
  endtask

  task automatic test_wait_hold;
    issue(1, 0, 2'd3, 0, 64'h8000_0008, 64'd0, 64'hfedc_ba98_7654_3210, 4);
    checks++;
    if ({held, rdy_low, lat, pulse1} !== {1'b1, 1'b1, 32'd5, 1'b1}) begin
      errors++; $display("FAIL ld_hold got held=%b rdylow=%b lat=%0d p=%b exp 1 1 5 1", held, rdy_low, lat, pulse1);
    end
    checks++;
    if (r !== 64'hfedc_ba98_7654_3210 || m !== 1'b0) begin
      errors++; $display("FAIL ld_rdata got %h m=%b exp fedcba9876543210 0", r, m);
    end
  endtask

  task automatic test_reset_wait;
    logic bad;
    bus.op_valid = 1; bus.op_load = 0; bus.op_store = 1; bus.op_size = 2'd2;
    bus.op_addr = 64'h8000_0004; bus.op_wdata = 64'h55aa_55aa;
    @(posedge clk); #1;
    bus.op_valid = 0;
    @(posedge clk); #1;
    checks++;
    if (bus.dreq.valid !== 1'b1) begin
      errors++; $display("FAIL rstwait_pre got valid=%b exp 1", bus.dreq.valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.dreq.valid, bus.done} !== 2'b00) begin
      errors++; $display("FAIL rstwait_drop got %b exp 00", {bus.dreq.valid, bus.done});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    bus.dresp.data_ok = 1'b1;
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done || bus.dreq.valid || !bus.op_ready) bad = 1;
    end
    bus.dresp.data_ok = 1'b0;
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL rstwait_late got bad=%b exp 0", bad);
    end
  endtask

  task automatic test_idle_ignore;
    logic bad;
    logic [63:0] keep;
    keep = bus.rdata;
    bad  = 0;
    bus.op_valid = 1; bus.op_load = 0; bus.op_store = 0;
    bus.dresp.data_ok = 1; bus.dresp.data = 64'h1111;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.done || bus.dreq.valid || !bus.op_ready || bus.rdata !== keep) bad = 1;
    end
    bus.op_valid = 0; bus.dresp.data_ok = 0;
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL idle_ignore got bad=%b exp 0", bad);
    end
  endtask

  task automatic test_back_to_back;
    issue(1, 0, 2'd2, 0, 64'h8000_0004, 64'd0, 64'h8000_0000_0000_0000, 1);
    checks++;
    if (r !== 64'hffff_ffff_8000_0000) begin
      errors++; $display("FAIL lw_sext got %h exp ffffffff80000000", r);
    end
    issue(1, 0, 2'd2, 1, 64'h8000_0004, 64'd0, 64'h8000_0000_0000_0000, 1);
    checks++;
    if (r !== 64'h0000_0000_8000_0000 || waited != 0) begin
      errors++; $display("FAIL lwu_b2b got %h waited=%0d exp 80000000 0", r, waited);
    end
  endtask

  task automatic test_random;
    logic        ld, st, uns, mis;
    logic [1:0]  sz;
    logic [63:0] a, wd, rd, er;
    logic [7:0]  es;
    int          k;
    for (int n = 0; n < 150; n++) begin
      ld  = 1'($urandom);
      st  = ld ? 1'($urandom) : 1'b1;
      sz  = 2'($urandom);
      uns = 1'($urandom);
      a   = {$urandom, $urandom};
      if ($urandom_range(3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      wd  = {$urandom, $urandom};
      rd  = {$urandom, $urandom};
      k   = $urandom_range(1, 4);
      mis = m_mis(a, sz);
      issue(ld, st, sz, uns, a, wd, rd, k);
      er  = (mis || !ld) ? 64'd0 : m_rdata(rd, a[2:0], sz, uns);
      es  = ld ? 8'h00 : m_strb(a[2:0], sz);
      checks++;
      if (lat != (mis ? 1 : k + 1) || {saw_v, held, rdy_low, pulse1, m} !== {!mis, 1'b1, 1'b1, 1'b1, mis}) begin
        errors++; $display("FAIL rnd%0d_ctl got lat=%0d flags=%b exp lat=%0d mis=%b", n, lat, {saw_v, held, rdy_low, pulse1, m}, mis ? 1 : k + 1, mis);
      end
      checks++;
      if (r !== er) begin
        errors++; $display("FAIL rnd%0d_rdata got %h exp %h", n, r, er);
      end
      if (!mis) begin
        checks++;
        if ({q_addr, q_size, q_strb} !== {a, 1'b0, sz, es}) begin
          errors++; $display("FAIL rnd%0d_req got %h/%0d/%h exp %h/%0d/%h", n, q_addr, q_size, q_strb, a, sz, es);
        end
        if (!ld) begin
          checks++;
          if (q_data !== wd << (int'(a[2:0]) * 8)) begin
            errors++; $display("FAIL rnd%0d_wdata got %h exp %h", n, q_data, wd << (int'(a[2:0]) * 8));
          end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_byte_load;
    test_half_store;
    test_misalign;
    test_wait_hold;
    test_reset_wait;
    test_idle_ignore;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store alignment stage between the execute stage and the data-memory access stage that drives the data bus.
- Accepts one load or store per handshake and validates natural alignment.
- Builds a lane-correct dbus request (size, byte strobe, shifted write data) and holds it stable until the bus completes.
- Extracts and sign/zero-extends load data from the returned 64-bit bus word, then reports completion with a one-cycle done pulse.

Parameters:
XLEN, 64, data/address width; only 64 supported
BUS_BYTES, 8, bytes per bus beat; lane offset = addr[2:0]

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
op_valid  input  1  operation presented
op_ready  output  1  stage can accept; high only in IDLE
op_load  input  1  operation is a load (wins if op_store also high)
op_store  input  1  operation is a store
op_size  input  2  0=byte 1=half 2=word 3=dword
op_unsigned  input  1  loads: zero-extend when 1, sign-extend when 0
op_addr  input  64  byte address
op_wdata  input  64  store data, right-aligned
dreq  output  dbus_req_t  valid/addr/size/strobe/data to data bus
dresp  input  dbus_resp_t  data_ok/data from data bus; addr_ok ignored
done  output  1  one-cycle completion pulse
rdata  output  64  extended load result; 0 for stores and misaligned ops
misalign  output  1  high with done when op was misaligned

Behaviour:
- Reset (rst low, async): state=IDLE; dreq.valid=0; dreq.addr/size/strobe/data=0; done=0; misalign=0; rdata=0; op_ready=1 once released.
- States: IDLE, WAIT, RESP.
- IDLE: op_ready=1. Accept on clock edge where op_valid & op_ready & (op_load | op_store). op_valid with neither load nor store is dropped; no response.
- Misalignment: op_addr mod 2^op_size != 0.
  - No bus request is issued.
  - Go to RESP with misalign=1 and rdata=0; done occurs the cycle after accept.
- Aligned accept: go to WAIT; dreq fields are registered and valid from the next cycle.
  - dreq.addr = op_addr (not aligned down).
  - dreq.size = {1'b0, op_size}.
  - Load: strobe = 0.
  - Store: strobe = ((1 << 2^op_size) - 1) << addr[2:0], 8 bits; dreq.data = op_wdata << (addr[2:0]*8), 64-bit truncated.
- WAIT: dreq held bit-stable. On the edge with dresp.data_ok=1:
  - dreq.valid <= 0.
  - For loads, capture sh = dresp.data >> (addr[2:0]*8); keep the low 8/16/32/64 bits per size; extend per op_unsigned into rdata. Dword ignores op_unsigned.
  - Stores: rdata <= 0.
  - Go to RESP.
- RESP: done=1 for exactly one cycle, misalign as latched; op_ready=0; next state IDLE.
- Latency:
  - Accept at edge T → dreq.valid from T+1.
  - data_ok sampled at edge T+k (k≥1) → done during cycle T+k+1.
  - Minimum aligned accept-to-done is 2 cycles; misaligned is 1 cycle.
- rdata and misalign hold their values after done until the next completion overwrites them.
- Back-to-back: a new op can be accepted on the first IDLE cycle after RESP; the pipeline issues at most 1 op per 3 cycles.
- dresp.data_ok in IDLE or RESP is ignored; no state or output change.
- Reset asserted in WAIT: dreq.valid drops immediately and the in-flight op is abandoned with no done; a late data_ok after release is ignored.
- op_* inputs are sampled only at accept; later changes do not affect the in-flight request.

Test Plan:
- lb at 0x8000_0002, data_ok next cycle with data=0x0123_4567_89AB_CDEF → dreq.size=0, strobe=0, rdata=0xFFFF_FFFF_FFFF_FFAB, done 2 cycles after accept; same with lbu → rdata=0x0000_0000_0000_00AB.
- sh at 0x8000_0006, wdata=0x1234 → dreq.size=1, strobe=0xC0, data=0x1234_0000_0000_0000; after data_ok, done=1, rdata=0, misalign=0.
- lw at 0x8000_0002 → dreq.valid never asserts; done=1 and misalign=1 the cycle after accept; rdata=0.
- ld at 0x8000_0008, data_ok withheld 3 cycles → dreq held unchanged and op_ready=0 throughout; done exactly one cycle after the data_ok edge; rdata equals the bus data.
- sw at 0x8000_0004 then rst pulsed low mid-WAIT, then data_ok=1 → dreq.valid=0 immediately, no done, state returns to IDLE with op_ready=1.
- lw at 0x8000_0004, data=0x8000_0000_0000_0000 (signed) → rdata=0xFFFF_FFFF_8000_0000; followed immediately by lwu at the same address and data → rdata=0x0000_0000_8000_0000, accepted the cycle after the first done.
